// File: rtl/vote_tally_pkg.sv
// Shared voting definitions: poll FSM state encodings and candidate codes.
package vote_tally_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_COMPARE = 2'd2,
    ST_CLOSED  = 2'd3
  } state_t;

  localparam logic CAND_A = 1'b0;
  localparam logic CAND_B = 1'b1;

endpackage

// File: rtl/vote_tally_sat_counter.sv
// Saturating per-candidate counter with synchronous clear; count registered, 1-cycle update.
// No backpressure: increments at the maximum value are dropped and flagged through at_max.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);

  assign at_max = &count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/vote_tally.sv
// Two-candidate poll: counts strobed votes while open, latches winner/tie one cycle after close.
// Latency: counts visible 1 cycle after a vote, result 2 cycles after close_req; no backpressure.
module vote_tally
  import vote_tally_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vote_enable,
  input  logic             current_candidate,
  input  logic             vote_done,
  input  logic             open_req,
  input  logic             close_req,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic [CNT_W:0]   total,
  output logic             poll_open,
  output logic             result_valid,
  output logic             winner,
  output logic             tie,
  output logic             sat_flag,
  output logic             proto_err,
  output logic             vote_reject
);

  state_t state;
  logic   in_open;
  logic   start;
  logic   accept;
  logic   inc_a;
  logic   inc_b;
  logic   a_max;
  logic   b_max;
  logic   hit_max;

  assign in_open = (state == ST_OPEN);
  assign start   = ((state == ST_IDLE) || (state == ST_CLOSED)) && open_req;
  assign accept  = in_open && vote_enable && vote_done;
  assign inc_a   = accept && (current_candidate == CAND_A);
  assign inc_b   = accept && (current_candidate == CAND_B);
  assign hit_max = (current_candidate == CAND_A) ? a_max : b_max;

  sat_counter #(.W(CNT_W)) u_cnt_a (
    .clk    (clk),
    .reset  (reset),
    .clear  (start),
    .inc    (inc_a),
    .count  (count_a),
    .at_max (a_max)
  );

  sat_counter #(.W(CNT_W)) u_cnt_b (
    .clk    (clk),
    .reset  (reset),
    .clear  (start),
    .inc    (inc_b),
    .count  (count_b),
    .at_max (b_max)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      total        <= '0;
      poll_open    <= 1'b0;
      result_valid <= 1'b0;
      winner       <= 1'b0;
      tie          <= 1'b0;
      sat_flag     <= 1'b0;
      proto_err    <= 1'b0;
      vote_reject  <= 1'b0;
    end else begin
      vote_reject <= vote_enable && !in_open;
      case (state)
        ST_IDLE, ST_CLOSED: begin
          if (open_req) begin
            state        <= ST_OPEN;
            poll_open    <= 1'b1;
            total        <= '0;
            result_valid <= 1'b0;
            winner       <= 1'b0;
            tie          <= 1'b0;
            sat_flag     <= 1'b0;
            proto_err    <= 1'b0;
          end
        end
        ST_OPEN: begin
          // A saturated candidate keeps total consistent with count_a + count_b.
          if (accept) begin
            if (hit_max) sat_flag <= 1'b1;
            else         total    <= total + 1'b1;
          end
          if (vote_enable ^ vote_done) proto_err <= 1'b1;
          if (close_req) begin
            state     <= ST_COMPARE;
            poll_open <= 1'b0;
          end
        end
        ST_COMPARE: begin
          state        <= ST_CLOSED;
          result_valid <= 1'b1;
          winner       <= (count_b > count_a);
          tie          <= (count_a == count_b);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_tally.sv
// Directed bench for vote_tally: a default-width instance plus a CNT_W=2 instance on shared stimulus.
module tb_vote_tally;

  logic clk = 1'b0;
  logic reset;
  logic vote_enable, current_candidate, vote_done, open_req, close_req;

  logic [7:0] d_count_a, d_count_b;
  logic [8:0] d_total;
  logic       d_poll_open, d_result_valid, d_winner, d_tie, d_sat_flag, d_proto_err, d_vote_reject;
  logic [1:0] n_count_a, n_count_b;
  logic [2:0] n_total;
  logic       n_poll_open, n_result_valid, n_winner, n_tie, n_sat_flag, n_proto_err, n_vote_reject;

  typedef struct {
    int a;
    int b;
    int tot;
    int win;
    int tie;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ma = 0;
  int   mb = 0;
  bit   model_open = 0;

  always #5 clk = ~clk;

  vote_tally dut (
    .clk(clk), .reset(reset), .vote_enable(vote_enable), .current_candidate(current_candidate),
    .vote_done(vote_done), .open_req(open_req), .close_req(close_req),
    .count_a(d_count_a), .count_b(d_count_b), .total(d_total), .poll_open(d_poll_open),
    .result_valid(d_result_valid), .winner(d_winner), .tie(d_tie), .sat_flag(d_sat_flag),
    .proto_err(d_proto_err), .vote_reject(d_vote_reject)
  );

  vote_tally #(.CNT_W(2)) dut_n (
    .clk(clk), .reset(reset), .vote_enable(vote_enable), .current_candidate(current_candidate),
    .vote_done(vote_done), .open_req(open_req), .close_req(close_req),
    .count_a(n_count_a), .count_b(n_count_b), .total(n_total), .poll_open(n_poll_open),
    .result_valid(n_result_valid), .winner(n_winner), .tie(n_tie), .sat_flag(n_sat_flag),
    .proto_err(n_proto_err), .vote_reject(n_vote_reject)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vote(input bit cand);
    vote_enable = 1'b1; vote_done = 1'b1; current_candidate = cand;
    if (model_open) begin
      if (cand) mb++; else ma++;
    end
    step();
    vote_enable = 1'b0; vote_done = 1'b0;
  endtask

  task automatic open_poll();
    open_req = 1'b1;
    step();
    open_req = 1'b0;
    ma = 0; mb = 0; model_open = 1;
  endtask

  // Pushes the expected result at close, pops it once result_valid appears.
  task automatic close_poll(input bit with_vote, input bit cand, input bit with_open);
    exp_t e, got;
    int   cyc;
    close_req = 1'b1; open_req = with_open;
    if (with_vote) begin
      vote_enable = 1'b1; vote_done = 1'b1; current_candidate = cand;
      if (cand) mb++; else ma++;
    end
    e.a = ma; e.b = mb; e.tot = ma + mb;
    e.win = (mb > ma) ? 1 : 0;
    e.tie = (ma == mb) ? 1 : 0;
    exp_q.push_back(e);
    step();
    close_req = 1'b0; open_req = 1'b0; vote_enable = 1'b0; vote_done = 1'b0;
    model_open = 0;
    chk("compare_poll_open", d_poll_open, 0);
    chk("compare_rv_low", d_result_valid, 0);
    cyc = 1;
    while (!d_result_valid && cyc < 6) begin
      step();
      cyc++;
    end
    chk("rv_latency", cyc, 2);
    got = exp_q.pop_front();
    chk("res_count_a", d_count_a, got.a);
    chk("res_count_b", d_count_b, got.b);
    chk("res_total", d_total, got.tot);
    chk("res_winner", d_winner, got.win);
    chk("res_tie", d_tie, got.tie);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; vote_enable = 0; current_candidate = 0; vote_done = 0; open_req = 0; close_req = 0;
    step(); step();
    chk("rst_count_a", d_count_a, 0);
    chk("rst_total", d_total, 0);
    chk("rst_poll_open", d_poll_open, 0);
    chk("rst_result_valid", d_result_valid, 0);
    chk("rst_flags", {d_sat_flag, d_proto_err, d_vote_reject}, 0);
    reset = 1'b0;
    step();

    // Vote while IDLE: one reject pulse, nothing counted.
    vote(0);
    chk("idle_reject", d_vote_reject, 1);
    chk("idle_count_a", d_count_a, 0);
    step();
    chk("idle_reject_end", d_vote_reject, 0);

    // 3 A, 2 B -> A wins.
    open_poll();
    chk("open_poll_open", d_poll_open, 1);
    vote(0); vote(1); vote(0); vote(1);
    vote(0);
    chk("run_count_a", d_count_a, 3);
    chk("run_total", d_total, 5);
    close_poll(0, 0, 0);

    // CLOSED holds its result; close_req and votes are ignored.
    close_req = 1'b1; step(); close_req = 1'b0;
    vote(1);
    chk("closed_reject", d_vote_reject, 1);
    step();
    chk("closed_rv", d_result_valid, 1);
    chk("closed_winner", d_winner, 0);
    chk("closed_count_b", d_count_b, 2);

    // 2 A, 2 B -> tie.
    open_poll();
    chk("reopen_clear_a", d_count_a, 0);
    chk("reopen_clear_rv", d_result_valid, 0);
    vote(0); vote(1); vote(1); vote(0);
    close_poll(0, 0, 0);

    // Protocol errors, ignored open_req, close with simultaneous B vote and open_req.
    open_poll();
    vote_enable = 1'b1; step(); vote_enable = 1'b0;
    chk("proto_en_only", d_proto_err, 1);
    chk("proto_counts", d_total, 0);
    vote_done = 1'b1; step(); vote_done = 1'b0;
    chk("proto_done_only", d_total, 0);
    vote(0); vote(1);
    open_req = 1'b1; step(); open_req = 1'b0;
    chk("open_in_open_ignored", d_count_a, 1);
    chk("proto_sticky", d_proto_err, 1);
    close_poll(1, 1, 1);
    chk("close_state_closed", d_poll_open, 0);

    // Saturation on the narrow instance.
    open_poll();
    chk("reopen_proto_clear", d_proto_err, 0);
    vote(0); vote(0); vote(0);
    chk("n_at_max", n_count_a, 3);
    chk("n_sat_before", n_sat_flag, 0);
    vote(0);
    chk("n_sat_count_a", n_count_a, 3);
    chk("n_sat_total", n_total, 3);
    chk("n_sat_flag", n_sat_flag, 1);
    chk("d_no_sat", d_sat_flag, 0);
    close_poll(0, 0, 0);
    chk("n_result", {n_result_valid, n_winner, n_tie}, 3'b100);

    // Asynchronous reset during OPEN.
    open_poll();
    vote(0); vote(0);
    chk("pre_rst_count_a", d_count_a, 2);
    reset = 1'b1;
    #1;
    chk("async_count_a", d_count_a, 0);
    chk("async_total", d_total, 0);
    chk("async_poll_open", d_poll_open, 0);
    chk("async_n_count_a", n_count_a, 0);
    step();
    reset = 1'b0;
    model_open = 0;
    step();
    vote(0);
    chk("post_rst_reject", d_vote_reject, 1);
    chk("post_rst_count_a", d_count_a, 0);
    chk("post_rst_poll_open", d_poll_open, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
